// File: rtl/difftest_commit_buf_pkg.sv
// Shared constants for the multi-lane difftest commit buffer.
//   TRAP_OPCODE      : major opcode of the simulation trap instruction
//   *_DEF            : default lane count / FIFO depth / register width
//   *_W              : entry field widths
//   entry_width()    : packed FIFO entry width for a given XLEN
//   is_trap()        : trap-opcode match on a 32-bit instruction
package difftest_commit_buf_pkg;

    localparam logic [6:0] TRAP_OPCODE = 7'h6b;

    localparam int NCOMMIT_DEF = 2;
    localparam int DEPTH_DEF   = 8;
    localparam int XLEN_DEF    = 64;

    localparam int INST_W  = 32;
    localparam int WNUM_W  = 5;
    localparam int WDEST_W = 8;
    localparam int CODE_W  = 8;

    // Entry layout, LSB first: pc, wdata, inst, wnum, we, trap.
    function automatic int entry_width(input int xlen);
        return 2 * xlen + INST_W + WNUM_W + 2;
    endfunction

    function automatic logic is_trap(input logic [INST_W-1:0] inst);
        return inst[6:0] == TRAP_OPCODE;
    endfunction

endpackage

// File: rtl/difftest_commit_buf_if.sv
// Writeback-in / commit-out bundle of the difftest commit buffer.
//   wb_*       : per-lane retire group from writeback, lane 0 oldest
//   in_ready   : buffer can take a full NCOMMIT group this cycle
//   cmt_*      : per-lane head entries presented to difftest, oldest first
//   cmt_ready  : consumer takes every presented valid lane this cycle
// master = environment (writeback + difftest), slave = the buffer.
interface difftest_commit_buf_if
    import difftest_commit_buf_pkg::*;
#(
    parameter int NCOMMIT = NCOMMIT_DEF,
    parameter int XLEN    = XLEN_DEF
);
    logic [NCOMMIT-1:0]         wb_valid;
    logic [NCOMMIT*XLEN-1:0]    wb_pc;
    logic [NCOMMIT*INST_W-1:0]  wb_inst;
    logic [NCOMMIT-1:0]         wb_we;
    logic [NCOMMIT*WNUM_W-1:0]  wb_wnum;
    logic [NCOMMIT*XLEN-1:0]    wb_wdata;
    logic                       in_ready;

    logic                       cmt_ready;
    logic [NCOMMIT-1:0]         cmt_valid;
    logic [NCOMMIT*XLEN-1:0]    cmt_pc;
    logic [NCOMMIT*INST_W-1:0]  cmt_inst;
    logic [NCOMMIT-1:0]         cmt_wen;
    logic [NCOMMIT*WDEST_W-1:0] cmt_wdest;
    logic [NCOMMIT*XLEN-1:0]    cmt_wdata;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_we, wb_wnum, wb_wdata, cmt_ready,
        input  in_ready, cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_we, wb_wnum, wb_wdata, cmt_ready,
        output in_ready, cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata
    );

endinterface

// File: rtl/difftest_commit_fifo.sv
// Multi-port circular buffer: up to NPORT pushes and NPORT pops per cycle.
//   clk, rst_n : clock, synchronous active-low reset (pointers/count only)
//   push_n     : number of compacted entries in push_data[0..push_n-1]
//   push_data  : NPORT packed entries, slot 0 written at tail
//   pop_n      : entries retired from the head this cycle (<= count)
//   count      : current occupancy
//   head_data  : NPORT entries starting at head, read combinationally
// The caller guarantees push_n fits and pop_n <= count.
module difftest_commit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NPORT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(DEPTH+1)-1:0] push_n,
    input  logic [NPORT*WIDTH-1:0]     push_data,
    input  logic [$clog2(DEPTH+1)-1:0] pop_n,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [NPORT*WIDTH-1:0]     head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    // NOTE: storage has no reset; only head/tail/count define which slots
    // are live, so stale data is never presented as valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (CW'(i) < push_n) begin
                // Pointer arithmetic wraps modulo DEPTH (power of two).
                mem[tail + AW'(i)] <= push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    always_comb begin
        head_data = '0;
        for (int k = 0; k < NPORT; k++) begin
            head_data[k*WIDTH +: WIDTH] = mem[head + AW'(k)];
        end
    end

endmodule

// File: rtl/difftest_commit_buf.sv
// Multi-lane difftest commit buffer.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : writeback group in, commit lanes out (see interface)
//   a0_i         : architectural a0; low byte becomes the trap code
//   trap_valid   : trap instruction has committed (sticky)
//   trap_code    : a0[7:0] captured when the trap entry was accepted
//   trap_pc      : PC of the trap instruction
//   cycle_cnt    : cycles since reset, frozen once trap_valid is set
//   instr_cnt    : committed instructions, frozen once trap_valid is set
//   err_overflow : sticky; a valid writeback arrived while !in_ready
module difftest_commit_buf
    import difftest_commit_buf_pkg::*;
#(
    parameter int NCOMMIT = NCOMMIT_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    difftest_commit_buf_if.slave  bus,
    input  logic [XLEN-1:0]       a0_i,
    output logic                  trap_valid,
    output logic [CODE_W-1:0]     trap_code,
    output logic [XLEN-1:0]       trap_pc,
    output logic [63:0]           cycle_cnt,
    output logic [63:0]           instr_cnt,
    output logic                  err_overflow
);
    localparam int EW = entry_width(XLEN);
    localparam int CW = $clog2(DEPTH+1);

    localparam int PC_LSB    = 0;
    localparam int WDATA_LSB = XLEN;
    localparam int INST_LSB  = 2 * XLEN;
    localparam int WNUM_LSB  = INST_LSB + INST_W;
    localparam int WE_BIT    = WNUM_LSB + WNUM_W;
    localparam int TRAP_BIT  = WE_BIT + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NC_C    = CW'(NCOMMIT);

    logic [CW-1:0]         count;
    logic [CW-1:0]         grp_n;
    logic [CW-1:0]         push_n;
    logic [CW-1:0]         pop_n;
    logic [NCOMMIT*EW-1:0] push_data;
    logic [NCOMMIT*EW-1:0] head_data;
    logic                  grp_trap;
    logic                  trap_seen;
    logic [CODE_W-1:0]     pend_code;
    logic                  pop_trap;
    logic [XLEN-1:0]       pop_trap_pc;
    logic [EW-1:0]         in_ent;
    logic [EW-1:0]         out_ent;
    logic                  unused_a0_hi;

    assign unused_a0_hi = ^a0_i[XLEN-1:CODE_W];

    // Space is judged on the pre-pop count; a same-cycle pop frees nothing.
    assign bus.in_ready = (DEPTH_C - count >= NC_C) && !trap_seen;

    // Compact valid lanes to the low slots. The first trap lane closes the
    // group: later lanes are dropped silently (they never reach the FIFO).
    // NOTE: every always_comb output gets a default first so no path
    // through the loop leaves a variable unassigned (no inferred latch).
    always_comb begin
        push_data = '0;
        grp_n     = '0;
        grp_trap  = 1'b0;
        in_ent    = '0;
        for (int k = 0; k < NCOMMIT; k++) begin
            if (bus.wb_valid[k] && !grp_trap) begin
                in_ent = '0;
                in_ent[PC_LSB    +: XLEN]   = bus.wb_pc[k*XLEN +: XLEN];
                in_ent[WDATA_LSB +: XLEN]   = bus.wb_wdata[k*XLEN +: XLEN];
                in_ent[INST_LSB  +: INST_W] = bus.wb_inst[k*INST_W +: INST_W];
                in_ent[WNUM_LSB  +: WNUM_W] = bus.wb_wnum[k*WNUM_W +: WNUM_W];
                in_ent[WE_BIT]              = bus.wb_we[k];
                in_ent[TRAP_BIT]            = is_trap(bus.wb_inst[k*INST_W +: INST_W]);
                push_data[int'(grp_n)*EW +: EW] = in_ent;
                grp_n    = grp_n + 1'b1;
                grp_trap = in_ent[TRAP_BIT];
            end
        end
    end

    assign push_n = bus.in_ready ? grp_n : '0;
    assign pop_n  = !bus.cmt_ready ? '0 : ((count >= NC_C) ? NC_C : count);

    difftest_commit_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .NPORT (NCOMMIT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .count     (count),
        .head_data (head_data)
    );

    // Present head entries and spot the trap entry among those popping.
    always_comb begin
        bus.cmt_valid = '0;
        bus.cmt_pc    = '0;
        bus.cmt_inst  = '0;
        bus.cmt_wen   = '0;
        bus.cmt_wdest = '0;
        bus.cmt_wdata = '0;
        pop_trap      = 1'b0;
        pop_trap_pc   = '0;
        out_ent       = '0;
        for (int k = 0; k < NCOMMIT; k++) begin
            out_ent = head_data[k*EW +: EW];
            bus.cmt_valid[k]                   = count > CW'(k);
            bus.cmt_pc[k*XLEN +: XLEN]         = out_ent[PC_LSB +: XLEN];
            bus.cmt_wdata[k*XLEN +: XLEN]      = out_ent[WDATA_LSB +: XLEN];
            bus.cmt_inst[k*INST_W +: INST_W]   = out_ent[INST_LSB +: INST_W];
            bus.cmt_wen[k]                     = out_ent[WE_BIT];
            bus.cmt_wdest[k*WDEST_W +: WDEST_W] =
                {{(WDEST_W-WNUM_W){1'b0}}, out_ent[WNUM_LSB +: WNUM_W]};
            if (CW'(k) < pop_n && out_ent[TRAP_BIT]) begin
                pop_trap    = 1'b1;
                pop_trap_pc = out_ent[PC_LSB +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_seen    <= 1'b0;
            pend_code    <= '0;
            trap_valid   <= 1'b0;
            trap_code    <= '0;
            trap_pc      <= '0;
            cycle_cnt    <= '0;
            instr_cnt    <= '0;
            err_overflow <= 1'b0;
        end else begin
            // Only one trap can ever be accepted: trap_seen closes in_ready.
            if (bus.in_ready && grp_trap) begin
                trap_seen <= 1'b1;
                pend_code <= a0_i[CODE_W-1:0];
            end
            if ((|bus.wb_valid) && !bus.in_ready) begin
                err_overflow <= 1'b1;
            end
            // The pop carrying the trap is still counted, then all freeze.
            if (!trap_valid) begin
                cycle_cnt <= cycle_cnt + 64'd1;
                instr_cnt <= instr_cnt + 64'(pop_n);
                if (pop_trap) begin
                    trap_valid <= 1'b1;
                    trap_code  <= pend_code;
                    trap_pc    <= pop_trap_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_difftest_commit_buf.sv
// Self-checking bench for difftest_commit_buf (NCOMMIT=2, DEPTH=8, XLEN=64).
// A queue-based model tracks the committed stream; every cycle the DUT
// outputs are compared against it, and directed phases pin literal values.
module tb_difftest_commit_buf;
    localparam int NC    = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  wnum;
        logic [63:0] wdata;
        logic        trap;
        logic [7:0]  code;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a0_i = '0;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    logic        err_overflow;

    difftest_commit_buf_if #(.NCOMMIT(NC), .XLEN(XLEN)) bus ();

    difftest_commit_buf #(.NCOMMIT(NC), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .a0_i         (a0_i),
        .trap_valid   (trap_valid),
        .trap_code    (trap_code),
        .trap_pc      (trap_pc),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    ent_t        m_q[$];
    bit          m_known = 1'b0;
    bit          m_trap_seen, m_trap_valid, m_err;
    logic [7:0]  m_trap_code;
    logic [63:0] m_trap_pc, m_cycle, m_instr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        int   sz;
        logic [NC-1:0] ev;
        if (!m_known) return;
        sz = m_q.size();
        ev = '0;
        for (int k = 0; k < NC; k++) ev[k] = (sz > k);
        check("in_ready", 64'(bus.in_ready), 64'((DEPTH - sz >= NC) && !m_trap_seen));
        check("cmt_valid", 64'(bus.cmt_valid), 64'(ev));
        for (int k = 0; k < NC && k < sz; k++) begin
            check($sformatf("cmt_pc[%0d]", k), bus.cmt_pc[k*64 +: 64], m_q[k].pc);
            check($sformatf("cmt_inst[%0d]", k), 64'(bus.cmt_inst[k*32 +: 32]), 64'(m_q[k].inst));
            check($sformatf("cmt_wen[%0d]", k), 64'(bus.cmt_wen[k]), 64'(m_q[k].we));
            check($sformatf("cmt_wdest[%0d]", k), 64'(bus.cmt_wdest[k*8 +: 8]), 64'(m_q[k].wnum));
            check($sformatf("cmt_wdata[%0d]", k), bus.cmt_wdata[k*64 +: 64], m_q[k].wdata);
        end
        check("trap_valid", 64'(trap_valid), 64'(m_trap_valid));
        check("trap_code", 64'(trap_code), 64'(m_trap_code));
        check("trap_pc", trap_pc, m_trap_pc);
        check("cycle_cnt", cycle_cnt, m_cycle);
        check("instr_cnt", instr_cnt, m_instr);
        check("err_overflow", 64'(err_overflow), 64'(m_err));
    endtask

    // Applies one clock edge worth of behaviour using the inputs held
    // across that edge.
    task automatic model_update();
        bit   ready, popped_trap;
        int   npop;
        ent_t e;
        logic [63:0] tp;
        logic [7:0]  tc;
        if (!rst_n) begin
            m_q.delete();
            m_known = 1'b1;
            m_trap_seen = 0; m_trap_valid = 0; m_err = 0;
            m_trap_code = '0; m_trap_pc = '0; m_cycle = '0; m_instr = '0;
            return;
        end
        if (!m_known) return;
        ready = (DEPTH - m_q.size() >= NC) && !m_trap_seen;
        npop  = bus.cmt_ready ? ((m_q.size() < NC) ? m_q.size() : NC) : 0;
        popped_trap = 0; tp = '0; tc = '0;
        for (int i = 0; i < npop; i++) begin
            e = m_q.pop_front();
            if (e.trap) begin popped_trap = 1; tp = e.pc; tc = e.code; end
        end
        if (!m_trap_valid) begin
            m_cycle += 1;
            m_instr += 64'(npop);
            if (popped_trap) begin
                m_trap_valid = 1; m_trap_pc = tp; m_trap_code = tc;
            end
        end
        if (ready) begin
            for (int k = 0; k < NC; k++) begin
                if (bus.wb_valid[k]) begin
                    e.pc    = bus.wb_pc[k*64 +: 64];
                    e.inst  = bus.wb_inst[k*32 +: 32];
                    e.we    = bus.wb_we[k];
                    e.wnum  = bus.wb_wnum[k*5 +: 5];
                    e.wdata = bus.wb_wdata[k*64 +: 64];
                    e.trap  = (e.inst[6:0] == 7'h6b);
                    e.code  = a0_i[7:0];
                    m_q.push_back(e);
                    if (e.trap) begin
                        m_trap_seen = 1;
                        break;
                    end
                end
            end
        end else if (|bus.wb_valid) begin
            m_err = 1;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next
    // negedge with post-edge outputs settled.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [31:0] plain_inst();
        logic [31:0] x;
        x = $urandom;
        if (x[6:0] == 7'h6b) x[0] = ~x[0];
        return x;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic [31:0] i0, input logic [31:0] i1, input logic rdy);
        bus.wb_valid  = v;
        bus.wb_pc     = {pc1, pc0};
        bus.wb_inst   = {i1, i0};
        bus.wb_we     = 2'($urandom);
        bus.wb_wnum   = 10'($urandom);
        bus.wb_wdata  = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        bus.cmt_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(2'b00, '0, '0, '0, '0, 1'b0);
        @(negedge clk);

        // Basic two-lane push, then pop.
        do_reset();
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        check("rst cmt_valid", 64'(bus.cmt_valid), 64'd0);
        check("rst cycle_cnt", cycle_cnt, 64'd0);
        drive(2'b11, 64'h8000_0000, 64'h8000_0004, plain_inst(), plain_inst(), 1'b1);
        step();
        check("t1 cmt_valid", 64'(bus.cmt_valid), 64'h3);
        check("t1 pc0", bus.cmt_pc[63:0], 64'h8000_0000);
        check("t1 pc1", bus.cmt_pc[127:64], 64'h8000_0004);
        check("t1 instr_cnt before", instr_cnt, 64'd0);
        drive(2'b00, '0, '0, '0, '0, 1'b1);
        step();
        check("t1 instr_cnt after", instr_cnt, 64'd2);

        // Lane 1 only lands at the head.
        drive(2'b10, 64'h0, 64'h8000_0010, plain_inst(), plain_inst(), 1'b0);
        step();
        check("t2 cmt_valid", 64'(bus.cmt_valid), 64'h1);
        check("t2 pc0", bus.cmt_pc[63:0], 64'h8000_0010);
        drive(2'b00, '0, '0, '0, '0, 1'b1);
        step();
        check("t2 instr_cnt", instr_cnt, 64'd3);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 64'h9000_0000 + 64'(16*i), 64'h9000_0004 + 64'(16*i),
                  plain_inst(), plain_inst(), 1'b0);
            step();
        end
        check("t3 in_ready full", 64'(bus.in_ready), 64'd0);
        drive(2'b11, 64'hdead, 64'hbeef, plain_inst(), plain_inst(), 1'b0);
        step();
        check("t3 err_overflow", 64'(err_overflow), 64'd1);
        check("t3 pc0 kept", bus.cmt_pc[63:0], 64'h9000_0000);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, '0, '0, '0, '0, 1'b1);
            step();
        end
        check("t3 drained", 64'(bus.cmt_valid), 64'd0);
        check("t3 instr_cnt", instr_cnt, 64'd11);

        // Trap in lane 0 discards lane 1 and freezes counters on commit.
        do_reset();
        a0_i = 64'h1234_5678_9abc_de05;
        drive(2'b11, 64'h8000_1000, 64'h8000_1004, 32'h0000_006b, plain_inst(), 1'b0);
        step();
        a0_i = 64'hff;
        check("t4 in_ready", 64'(bus.in_ready), 64'd0);
        check("t4 cmt_valid", 64'(bus.cmt_valid), 64'h1);
        drive(2'b00, '0, '0, '0, '0, 1'b1);
        step();
        check("t4 trap_valid", 64'(trap_valid), 64'd1);
        check("t4 trap_code", 64'(trap_code), 64'h05);
        check("t4 trap_pc", trap_pc, 64'h8000_1000);
        check("t4 cycle_cnt", cycle_cnt, 64'd2);
        check("t4 instr_cnt", instr_cnt, 64'd1);
        for (int i = 0; i < 3; i++) step();
        check("t4 cycle frozen", cycle_cnt, 64'd2);

        // Reset while five entries are in flight.
        do_reset();
        drive(2'b11, 64'h10, 64'h14, plain_inst(), plain_inst(), 1'b0);
        step();
        drive(2'b11, 64'h18, 64'h1c, plain_inst(), plain_inst(), 1'b0);
        step();
        drive(2'b01, 64'h20, 64'h24, plain_inst(), plain_inst(), 1'b0);
        step();
        check("t6 cmt_valid pre", 64'(bus.cmt_valid), 64'h3);
        do_reset();
        check("t6 cmt_valid", 64'(bus.cmt_valid), 64'd0);
        check("t6 in_ready", 64'(bus.in_ready), 64'd1);
        check("t6 cycle_cnt", cycle_cnt, 64'd0);
        check("t6 instr_cnt", instr_cnt, 64'd0);

        // Randomized traffic with occasional traps and resets.
        for (int c = 0; c < 800; c++) begin
            logic [31:0] i0, i1;
            i0 = ($urandom_range(0, 24) == 0) ? {$urandom} & 32'hffff_ff80 | 32'h6b : plain_inst();
            i1 = ($urandom_range(0, 24) == 0) ? {$urandom} & 32'hffff_ff80 | 32'h6b : plain_inst();
            a0_i = {32'($urandom), 32'($urandom)};
            drive(2'($urandom), {32'h8000_0000, 32'($urandom)}, {32'h8000_0000, 32'($urandom)},
                  i0, i1, $urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 99) == 0 || (m_trap_valid && $urandom_range(0, 5) == 0)) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
